// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared widths and requester indices for the register-file write scheduler
package regfile_sched_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int NUM_REGS = 2**DEF_ADDR_W;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; pointer flips to the other requester after every grant
module rr_arb2
  import regfile_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic r_ptr;
  assign grant = (&req) ? (r_ptr ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= 1'b0;
    else if (|grant) r_ptr <= grant[REQ_ALU];
  end
endmodule

// File: rtl/regfile_port_sched.sv
// regfile_port_sched: arbitrates ALU/MEM writebacks onto the register file write port
// and tracks pending writes to flag read-after-write hazards.
module regfile_port_sched
  import regfile_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              hazard,
  output logic              sb_err
);
  localparam int NREG = 2**ADDR_W;
  logic [1:0]        w_req, w_grant;
  logic              w_gnt, w_haz1, w_haz2;
  logic [ADDR_W-1:0] w_gnt_reg;
  logic [DATA_W-1:0] w_gnt_data;
  logic [NREG-1:0]   r_pending, w_set, w_clr;
  // no grants while in reset so nothing is accepted and then lost
  assign w_req[REQ_ALU] = alu_valid & ~rst;
  assign w_req[REQ_MEM] = mem_valid & ~rst;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(w_req), .grant(w_grant));
  assign alu_ready  = w_grant[REQ_ALU];
  assign mem_ready  = w_grant[REQ_MEM];
  assign w_gnt      = |w_grant;
  assign w_gnt_reg  = w_grant[REQ_MEM] ? mem_reg : alu_reg;
  assign w_gnt_data = w_grant[REQ_MEM] ? mem_data : alu_data;
  // bit 0 of the scoreboard never gets set or cleared, so it stays 0
  assign w_clr = (w_gnt && w_gnt_reg != '0) ? NREG'(1) << w_gnt_reg : '0;
  assign w_set = (rsv_valid && rsv_reg != '0) ? NREG'(1) << rsv_reg : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      sb_err     <= 1'b0;
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      r_pending <= w_set | (r_pending & ~w_clr);
      sb_err    <= |(w_set & r_pending & ~w_clr);
      RegWrite  <= w_gnt && w_gnt_reg != '0;
      if (w_gnt) begin
        write_reg  <= w_gnt_reg;
        write_data <= w_gnt_data;
      end
    end
  end
  // the in-flight term covers the gap between scoreboard clear and file commit
  assign w_haz1 = rd_reg1 != '0 && (r_pending[rd_reg1] || (RegWrite && write_reg == rd_reg1));
  assign w_haz2 = rd_reg2 != '0 && (r_pending[rd_reg2] || (RegWrite && write_reg == rd_reg2));
  assign hazard = w_haz1 | w_haz2;
endmodule
